// File: rtl/downsizing.sv
// Stream width converter 2W -> W: each input word leaves as two beats, upper half first.
// Optional DOWNSIZING_SINGLE_EN: honour in_tsingle so a word can emit only its upper half.
module downsizing #(
    parameter int W = 40
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [2*W-1:0] in_tdata,
    input  logic           in_tvalid,
    input  logic           in_tlast,
    input  logic           in_tsingle,
    output logic           in_tready,
    output logic [W-1:0]   out_tdata,
    output logic           out_tvalid,
    output logic           out_tlast,
    input  logic           out_tready
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // a source holds data/last stable while valid is high and ready is low.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        UPPER = 2'd1,
        LOWER = 2'd2
    } phase_t;

    phase_t         phase;
    logic [W-1:0]   hold_lo;
    logic           last;
    logic           single;

    logic           single_in;
    logic           final_beat;
    logic           in_xfer;
    logic           out_xfer;

`ifdef DOWNSIZING_SINGLE_EN
    assign single_in = in_tsingle;
`else
    logic unused_single;
    assign unused_single = in_tsingle;
    assign single_in     = 1'b0;
`endif

    assign final_beat = (phase == LOWER) || (phase == UPPER && single);
    // Combinational out_tready -> in_tready path lets a new word land on the final beat.
    assign in_tready  = !areset && ((phase == EMPTY) || (final_beat && out_tready));
    assign in_xfer    = in_tvalid && in_tready;
    assign out_xfer   = out_tvalid && out_tready;

    // The upper half goes straight into the output register, so only the lower half is held.
    always_ff @(posedge aclk) begin
        if (areset) begin
            phase      <= EMPTY;
            hold_lo    <= '0;
            last       <= 1'b0;
            single     <= 1'b0;
            out_tdata  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
        end else if (in_xfer) begin
            phase      <= UPPER;
            hold_lo    <= in_tdata[W-1:0];
            last       <= in_tlast;
            single     <= single_in;
            out_tdata  <= in_tdata[2*W-1:W];
            out_tvalid <= 1'b1;
            out_tlast  <= in_tlast && single_in;
        end else if (out_xfer) begin
            if (!final_beat) begin
                phase     <= LOWER;
                out_tdata <= hold_lo;
                out_tlast <= last;
            end else begin
                phase      <= EMPTY;
                out_tvalid <= 1'b0;
                out_tlast  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_downsizing.sv
// Directed bench for downsizing (W=40): reset, split, back-to-back, backpressure,
// single words and reset mid-packet, each against hand-computed beats.
module tb_downsizing;

    localparam int W = 40;

    logic           aclk = 1'b0;
    logic           areset;
    logic [2*W-1:0] in_tdata;
    logic           in_tvalid;
    logic           in_tlast;
    logic           in_tsingle;
    logic           in_tready;
    logic [W-1:0]   out_tdata;
    logic           out_tvalid;
    logic           out_tlast;
    logic           out_tready;

    int n_vec = 0;
    int n_err = 0;

    downsizing #(.W(W)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .in_tdata   (in_tdata),
        .in_tvalid  (in_tvalid),
        .in_tlast   (in_tlast),
        .in_tsingle (in_tsingle),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_tvalid (out_tvalid),
        .out_tlast  (out_tlast),
        .out_tready (out_tready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic look();
        @(negedge aclk);
    endtask

    task automatic check_beat(input string tag, input logic [W-1:0] data, input logic lst);
        check({tag, " valid"}, 80'(out_tvalid), 80'(1));
        check({tag, " data"}, 80'(out_tdata), 80'(data));
        check({tag, " last"}, 80'(out_tlast), 80'(lst));
    endtask

    logic [2*W-1:0] words [4];

    initial begin
        for (int i = 0; i < 4; i++) words[i] = {40'(2 * i + 1), 40'(2 * i + 2)};

        // reset held 3 cycles with in_tvalid asserted
        areset     = 1'b1;
        in_tvalid  = 1'b1;
        in_tdata   = {40'hDEADBEEF01, 40'hCAFEF00D02};
        in_tlast   = 1'b1;
        in_tsingle = 1'b0;
        out_tready = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            look();
            check("rst in_tready", 80'(in_tready), 80'(0));
            check("rst out_tvalid", 80'(out_tvalid), 80'(0));
            check("rst out_tlast", 80'(out_tlast), 80'(0));
            check("rst out_tdata", 80'(out_tdata), 80'(0));
            tick();
        end
        areset    = 1'b0;
        in_tvalid = 1'b0;
        look();
        check("post-rst in_tready", 80'(in_tready), 80'(1));
        check("post-rst out_tvalid", 80'(out_tvalid), 80'(0));
        tick();

        // basic split
        in_tdata  = {40'hAAAAAAAAAA, 40'h5555555555};
        in_tvalid = 1'b1;
        in_tlast  = 1'b1;
        look();
        check("split accept", 80'(in_tready), 80'(1));
        tick();
        in_tvalid = 1'b0;
        look();
        check_beat("split upper", 40'hAAAAAAAAAA, 1'b0);
        check("split upper in_tready", 80'(in_tready), 80'(0));
        tick();
        look();
        check_beat("split lower", 40'h5555555555, 1'b1);
        check("split lower in_tready", 80'(in_tready), 80'(1));
        tick();
        look();
        check("split idle valid", 80'(out_tvalid), 80'(0));
        tick();

        // back-to-back words, out_tready always 1
        for (int c = 0; c <= 8; c++) begin
            in_tvalid = (c <= 7);
            in_tdata  = words[(c / 2 > 3) ? 3 : c / 2];
            in_tlast  = (c / 2 == 3);
            look();
            check($sformatf("b2b in_tready c%0d", c), 80'(in_tready), 80'(c % 2 == 0));
            if (c == 0) check("b2b c0 valid", 80'(out_tvalid), 80'(0));
            else check_beat($sformatf("b2b c%0d", c), 40'(c), c == 8);
            tick();
        end
        in_tvalid = 1'b0;
        look();
        check("b2b idle valid", 80'(out_tvalid), 80'(0));
        tick();

        // backpressure during the LOWER beat
        in_tdata  = {40'hB0B0B0B0B1, 40'hC0C0C0C0C1};
        in_tvalid = 1'b1;
        in_tlast  = 1'b0;
        look();
        check("bp accept", 80'(in_tready), 80'(1));
        tick();
        in_tvalid = 1'b0;
        look();
        check_beat("bp upper", 40'hB0B0B0B0B1, 1'b0);
        tick();
        out_tready = 1'b0;
        in_tvalid  = 1'b1;
        in_tdata   = {40'hD0D0D0D0D1, 40'hE0E0E0E0E1};
        in_tlast   = 1'b1;
        for (int c = 0; c < 5; c++) begin
            look();
            check_beat($sformatf("bp stall%0d", c), 40'hC0C0C0C0C1, 1'b0);
            check($sformatf("bp stall%0d in_tready", c), 80'(in_tready), 80'(0));
            tick();
        end
        out_tready = 1'b1;
        look();
        check("bp release in_tready", 80'(in_tready), 80'(1));
        check_beat("bp release", 40'hC0C0C0C0C1, 1'b0);
        tick();
        in_tvalid = 1'b0;
        look();
        check_beat("bp next upper", 40'hD0D0D0D0D1, 1'b0);
        tick();
        look();
        check_beat("bp next lower", 40'hE0E0E0E0E1, 1'b1);
        tick();
        look();
        check("bp idle valid", 80'(out_tvalid), 80'(0));
        tick();

        // single word
        in_tdata   = {40'h1234567890, 40'hFFEEDDCCBB};
        in_tvalid  = 1'b1;
        in_tlast   = 1'b1;
        in_tsingle = 1'b1;
        look();
        check("single accept", 80'(in_tready), 80'(1));
        tick();
        in_tvalid  = 1'b0;
        in_tsingle = 1'b0;
        look();
`ifdef DOWNSIZING_SINGLE_EN
        check_beat("single beat", 40'h1234567890, 1'b1);
        check("single in_tready", 80'(in_tready), 80'(1));
        tick();
`else
        check_beat("single upper", 40'h1234567890, 1'b0);
        check("single in_tready", 80'(in_tready), 80'(0));
        tick();
        look();
        check_beat("single lower", 40'hFFEEDDCCBB, 1'b1);
        tick();
`endif
        look();
        check("single idle valid", 80'(out_tvalid), 80'(0));
        tick();

        // reset during UPPER
        in_tdata  = {40'h11, 40'h22};
        in_tvalid = 1'b1;
        in_tlast  = 1'b1;
        look();
        check("mid accept", 80'(in_tready), 80'(1));
        tick();
        in_tvalid = 1'b0;
        look();
        check_beat("mid upper", 40'h11, 1'b0);
        tick();
        areset = 1'b1;
        look();
        check("mid rst in_tready", 80'(in_tready), 80'(0));
        tick();
        areset = 1'b0;
        look();
        check("mid after valid", 80'(out_tvalid), 80'(0));
        check("mid after data", 80'(out_tdata), 80'(0));
        check("mid after in_tready", 80'(in_tready), 80'(1));
        tick();
        in_tdata  = {40'h33, 40'h44};
        in_tvalid = 1'b1;
        look();
        check("mid new accept", 80'(in_tready), 80'(1));
        tick();
        in_tvalid = 1'b0;
        look();
        check_beat("mid new upper", 40'h33, 1'b0);
        tick();
        look();
        check_beat("mid new lower", 40'h44, 1'b1);
        tick();
        look();
        check("mid idle valid", 80'(out_tvalid), 80'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
